// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller: FSM states, the command record,
// and a sizing helper for the latency counter.
package alu_issue_ctrl_pkg;

    localparam int CMD_OP_W   = 4;
    localparam int CMD_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [CMD_OP_W-1:0]          op;
        logic signed [CMD_WORD_W-1:0] a;
        logic signed [CMD_WORD_W-1:0] b;
    } cmd_t;

    // Latency counter must hold ALU_LATENCY; keep at least one bit for latency 0.
    function automatic int lat_cnt_w(input int latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_fifo.sv
// Command buffer: power-of-two circular FIFO with wrapping pointers and an
// occupancy count; the head is read from storage, so nothing bypasses it.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues buffered commands one at a time to an external ALU, waits its fixed
// latency, then holds the captured result until the consumer takes it.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int ALU_CON_SIZE = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int ALU_LATENCY  = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [ALU_CON_SIZE-1:0]        cmd_op,
    input  logic signed [WORD_SIZE-1:0]    cmd_a,
    input  logic signed [WORD_SIZE-1:0]    cmd_b,
    output logic [ALU_CON_SIZE-1:0]        alu_con,
    output logic signed [WORD_SIZE-1:0]    data_in_1,
    output logic signed [WORD_SIZE-1:0]    data_in_2,
    input  logic signed [WORD_SIZE-1:0]    data_out,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic signed [WORD_SIZE-1:0]    res_data,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           busy
);

    localparam int CMD_W = ALU_CON_SIZE + 2 * WORD_SIZE;
    localparam int LC_W  = lat_cnt_w(ALU_LATENCY);

    state_t            state;
    state_t            state_nxt;
    logic [LC_W-1:0]   lat_cnt;
    logic [CMD_W-1:0]  head;
    logic              push;
    logic              pop;
    logic              capture;
    logic              release_res;
    logic              fifo_full;
    logic              fifo_empty;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || (fifo_count != '0);

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata ({cmd_op, cmd_a, cmd_b}),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Handing off the result and issuing the next command share one edge.
                if (res_ready) begin
                    release_res = 1'b1;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_cnt   <= '0;
            alu_con   <= '0;
            data_in_1 <= '0;
            data_in_2 <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            if (pop) begin
                alu_con   <= head[CMD_W-1 -: ALU_CON_SIZE];
                data_in_1 <= $signed(head[2*WORD_SIZE-1 -: WORD_SIZE]);
                data_in_2 <= $signed(head[WORD_SIZE-1:0]);
                lat_cnt   <= LC_W'(ALU_LATENCY);
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LC_W'(1);
            end
            if (capture) begin
                res_data  <= data_out;
                res_valid <= 1'b1;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32, the operand and result width.
REQ-002 The block SHALL have parameter ALU_CON_SIZE, default 4, the ALU opcode width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4 (power of 2), the command buffer depth.
REQ-004 The block SHALL have parameter ALU_LATENCY, default 1, the number of rising edges from an operand change to a valid data_out.
REQ-005 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted.
- cmd_op  in  ALU_CON_SIZE  opcode.
- cmd_a  in  WORD_SIZE signed  operand 1.
- cmd_b  in  WORD_SIZE signed  operand 2.
- alu_con  out  ALU_CON_SIZE  opcode to the ALU.
- data_in_1  out  WORD_SIZE signed  operand 1 to the ALU.
- data_in_2  out  WORD_SIZE signed  operand 2 to the ALU.
- data_out  in  WORD_SIZE signed  ALU result.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts the result.
- res_data  out  WORD_SIZE signed  captured result.
- fifo_count  out  clog2(FIFO_DEPTH)+1  buffered command count.
- busy  out  1  high when the FSM is not IDLE or fifo_count is nonzero.

Function
REQ-006 The block SHALL accept a command on every rising edge where cmd_valid and cmd_ready are both high, writing {cmd_op, cmd_a, cmd_b} to the FIFO tail.
REQ-007 The block SHALL drive cmd_ready = (fifo_count != FIFO_DEPTH), combinationally from registered state only.
REQ-008 The FIFO SHALL use wrap-around read and write pointers; a push and a pop on the same edge SHALL leave fifo_count unchanged.
REQ-009 A command written on edge E SHALL NOT be popped before edge E+1 (no bypass path).
REQ-010 The FSM SHALL have three states: IDLE, WAIT and HOLD.
REQ-011 In IDLE with fifo_count>0, at the next edge the FSM SHALL pop the FIFO head into the registered alu_con, data_in_1 and data_in_2, load the latency counter with ALU_LATENCY, and enter WAIT.
REQ-012 In WAIT, the counter SHALL decrement on each edge; on the WAIT edge where the counter equals 0, the FSM SHALL register data_out into res_data, set res_valid, and enter HOLD.
REQ-013 Issue-to-capture latency SHALL be exactly ALU_LATENCY+1 edges; with ALU_LATENCY=1, an issue at edge E0 SHALL raise res_valid after edge E0+2.
REQ-014 In HOLD, res_valid and res_data SHALL remain stable until the edge where res_ready is high.
REQ-015 On the HOLD edge where res_ready is high, res_valid SHALL clear, and:
- with fifo_count>0: the FSM SHALL pop and issue in the same edge and enter WAIT;
- otherwise: the FSM SHALL enter IDLE.
REQ-016 alu_con, data_in_1 and data_in_2 SHALL hold their last issued values between operations.
REQ-017 Only one operation SHALL be in flight at a time.
REQ-018 In the full state, cmd_ready SHALL be low and cmd_valid SHALL be ignored; a simultaneous pop SHALL raise cmd_ready in the following cycle.
REQ-019 res_data SHALL capture data_out bit-exact, with no width change or sign manipulation.

Reset
REQ-020 Assertion of rstn low SHALL take effect immediately and asynchronously, and SHALL force:
- FSM to IDLE, pointers and fifo_count to 0, latency counter to 0;
- res_valid=0, res_data=0;
- alu_con=0, data_in_1=0, data_in_2=0.
REQ-021 Reset asserted during WAIT or HOLD SHALL discard the in-flight operation and all buffered commands, with no result emitted afterwards.
REQ-022 After reset release, cmd_ready SHALL be high in the first cycle.

Structure
REQ-023 A shared package SHALL hold the FSM state enum (IDLE, WAIT, HOLD) and the command struct type {op, a, b}, which is also used by the bench.
REQ-024 The FIFO SHALL be a separate sub-module named cmd_fifo, parameterised by width and depth, with the same clk/rstn convention.

Verification
The bench SHALL model the ALU as a registered adder with ALU_LATENCY=1, ignoring alu_con.
REQ-025 Single command: push a=5, b=7 at E0 -> issue at E1, res_valid after E3, res_data=12.
REQ-026 Signed arithmetic: push a=-3, b=1 -> res_data=32'hFFFFFFFE.
REQ-027 Full FIFO with res_ready low: push 6 commands 1+1 .. 6+6 -> one in flight plus 4 buffered, cmd_ready low, fifo_count=4, 6th command stalls; with res_ready then held high, results 2,4,6,8,10,12 emerge in order, one every 3 cycles.
REQ-028 Back-pressure: hold res_ready low for 10 cycles in HOLD -> res_data stable and no new issue; release -> next issue on the same edge.
REQ-029 Reset in WAIT: rstn low mid-operation -> all outputs zero immediately, fifo_count=0, and no res_valid after release.
REQ-030 Simultaneous push/pop at fifo_count=2 -> fifo_count stays 2, and data order is preserved across pointer wrap after 8+ commands.
